// File: rtl/boot_loader_ctrl.sv
// -----------------------------------------------------------------------------
// boot_loader_ctrl
//
// Purpose:
//   Boot-time loader that streams words from a valid/ready source into the
//   data BRAM and then the instruction BRAM. The core is held in stall until
//   the last instruction write has landed. It is then released by enabling
//   instruction fetch and register-file reads.
//
// Optional feature (macro BOOT_CHECKSUM_EN):
//   When defined, a 32-bit mod-2^32 sum of every loaded word is kept. One
//   extra source word is accepted after the instruction phase and compared
//   against that sum. A match releases the core (RUN). A mismatch parks the
//   loader in ERROR with o_err=1. When undefined there is no CHECK state and
//   no checksum register, and o_err is tied to 0.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_start                   one-cycle start pulse, honoured only in IDLE
//   i_d_count, i_i_count      data / instruction word counts, sampled on start
//   i_src_valid, i_src_data   source word stream
//   o_src_ready               loader accepts a word this cycle
//   o_d_w_addr/dat/enb        data BRAM write port (registered)
//   o_i_w_addr/dat/enb        instruction BRAM write port (registered)
//   o_d_bram_init_done        data BRAM handed to core; sticky until reset
//   o_pc_stall                holds the core PC
//   o_i_r_enb, o_rd_enbl      instruction fetch / register-file read enables
//   o_busy                    load in progress
//   o_err                     checksum mismatch (checksum build only)
// -----------------------------------------------------------------------------
module boot_loader_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [7:0]            i_d_count,
    input  logic [7:0]            i_i_count,
    input  logic                  i_src_valid,
    input  logic [DATA_WIDTH-1:0] i_src_data,
    output logic                  o_src_ready,
    output logic [ADDR_WIDTH-1:0] o_d_w_addr,
    output logic [DATA_WIDTH-1:0] o_d_w_dat,
    output logic                  o_d_w_enb,
    output logic [ADDR_WIDTH-1:0] o_i_w_addr,
    output logic [DATA_WIDTH-1:0] o_i_w_dat,
    output logic                  o_i_w_enb,
    output logic                  o_d_bram_init_done,
    output logic                  o_pc_stall,
    output logic                  o_i_r_enb,
    output logic                  o_rd_enbl,
    output logic                  o_busy,
    output logic                  o_err
);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StLoadD, StLoadI, StCheck, StRun, StError} state_e;
    localparam state_e EndState = StCheck;
`else
    typedef enum logic [2:0] {StIdle, StLoadD, StLoadI, StRun, StError} state_e;
    localparam state_e EndState = StRun;
`endif

    state_e                r_state;
    state_e                w_state_next;
    logic [7:0]            r_d_count;
    logic [7:0]            r_i_count;
    logic [7:0]            r_idx;
    logic                  r_src_ready;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_d_w_addr;
    logic [DATA_WIDTH-1:0] r_d_w_dat;
    logic                  r_d_w_enb;
    logic [ADDR_WIDTH-1:0] r_i_w_addr;
    logic [DATA_WIDTH-1:0] r_i_w_dat;
    logic                  r_i_w_enb;
    logic                  r_init_done;
    logic                  r_pc_stall;
    logic                  r_i_r_enb;
    logic                  r_rd_enbl;

    logic                  w_xfer;
    logic                  w_d_last;
    logic                  w_i_last;
    logic                  w_loading_next;
    logic [ADDR_WIDTH-1:0] w_addr;

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] r_sum;
    logic        r_err;
`endif

    always_comb begin
        w_xfer   = i_src_valid & r_src_ready;
        w_d_last = (r_idx == r_d_count - 8'd1);
        w_i_last = (r_idx == r_i_count - 8'd1);
        // Byte address of the current word; 8-bit index * 4 never exceeds 0x3FC.
        w_addr   = ADDR_WIDTH'({r_idx, 2'b00});

        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (i_d_count != 8'd0)      w_state_next = StLoadD;
                    else if (i_i_count != 8'd0) w_state_next = StLoadI;
                    else                        w_state_next = EndState;
                end
            end
            StLoadD: begin
                if (w_xfer && w_d_last) begin
                    w_state_next = (r_i_count != 8'd0) ? StLoadI : EndState;
                end
            end
            StLoadI: begin
                if (w_xfer && w_i_last) w_state_next = EndState;
            end
`ifdef BOOT_CHECKSUM_EN
            StCheck: begin
                if (w_xfer) w_state_next = (r_sum == 32'(i_src_data)) ? StRun : StError;
            end
`endif
            default: w_state_next = r_state;  // RUN and ERROR are terminal
        endcase

        w_loading_next = (w_state_next == StLoadD) || (w_state_next == StLoadI);
`ifdef BOOT_CHECKSUM_EN
        w_loading_next = w_loading_next || (w_state_next == StCheck);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_d_count   <= 8'd0;
            r_i_count   <= 8'd0;
            r_idx       <= 8'd0;
            r_src_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_d_w_addr  <= '0;
            r_d_w_dat   <= '0;
            r_d_w_enb   <= 1'b0;
            r_i_w_addr  <= '0;
            r_i_w_dat   <= '0;
            r_i_w_enb   <= 1'b0;
            r_init_done <= 1'b0;
            r_pc_stall  <= 1'b1;
            r_i_r_enb   <= 1'b0;
            r_rd_enbl   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_sum       <= 32'd0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_d_w_enb <= 1'b0;
            r_i_w_enb <= 1'b0;

            if (r_state == StIdle && i_start) begin
                r_d_count <= i_d_count;
                r_i_count <= i_i_count;
                r_idx     <= 8'd0;
`ifdef BOOT_CHECKSUM_EN
                r_sum     <= 32'd0;
`endif
            end

            if (w_xfer && r_state == StLoadD) begin
                r_d_w_enb  <= 1'b1;
                r_d_w_addr <= w_addr;
                r_d_w_dat  <= i_src_data;
            end
            if (w_xfer && r_state == StLoadI) begin
                r_i_w_enb  <= 1'b1;
                r_i_w_addr <= w_addr;
                r_i_w_dat  <= i_src_data;
            end
            if (w_xfer && (r_state == StLoadD || r_state == StLoadI)) begin
                // Index restarts whenever the phase changes on this transfer.
                r_idx <= (w_state_next != r_state) ? 8'd0 : r_idx + 8'd1;
`ifdef BOOT_CHECKSUM_EN
                r_sum <= r_sum + 32'(i_src_data);
`endif
            end

            r_src_ready <= w_loading_next;
            r_busy      <= w_loading_next;

            // Sticky: set once the data phase is over or was skipped.
            if (w_state_next != StIdle && w_state_next != StLoadD) r_init_done <= 1'b1;

            // Derived from the current state, so release trails RUN entry by one
            // cycle and the final instruction write lands before the first fetch.
            r_pc_stall <= (r_state != StRun);
            r_i_r_enb  <= (r_state == StRun);
            r_rd_enbl  <= (r_state == StRun);
`ifdef BOOT_CHECKSUM_EN
            r_err      <= (w_state_next == StError);
`endif
        end
    end

    assign o_src_ready        = r_src_ready;
    assign o_d_w_addr         = r_d_w_addr;
    assign o_d_w_dat          = r_d_w_dat;
    assign o_d_w_enb          = r_d_w_enb;
    assign o_i_w_addr         = r_i_w_addr;
    assign o_i_w_dat          = r_i_w_dat;
    assign o_i_w_enb          = r_i_w_enb;
    assign o_d_bram_init_done = r_init_done;
    assign o_pc_stall         = r_pc_stall;
    assign o_i_r_enb          = r_i_r_enb;
    assign o_rd_enbl          = r_rd_enbl;
    assign o_busy             = r_busy;
`ifdef BOOT_CHECKSUM_EN
    assign o_err              = r_err;
`else
    assign o_err              = 1'b0;
`endif

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boot_loader_ctrl
//
// Self-checking bench for boot_loader_ctrl. Each load builds its word list,
// pushes the expected BRAM writes into a scoreboard queue, and streams the
// words with a chosen valid pattern. A negedge monitor pops and compares every
// write strobe. It also records when d_bram_init_done rises and pc_stall falls.
// Honours BOOT_CHECKSUM_EN to exercise the checksum build.
// -----------------------------------------------------------------------------
module tb_boot_loader_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    dcnt = 8'd0;
    logic [7:0]    icnt = 8'd0;
    logic          valid = 1'b0;
    logic [DW-1:0] sdata = '0;

    logic          src_ready;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_dat;
    logic          d_enb;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_dat;
    logic          i_enb;
    logic          init_done;
    logic          pc_stall;
    logic          i_r_enb;
    logic          rd_enbl;
    logic          busy;
    logic          err;

    boot_loader_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_start           (start),
        .i_d_count         (dcnt),
        .i_i_count         (icnt),
        .i_src_valid       (valid),
        .i_src_data        (sdata),
        .o_src_ready       (src_ready),
        .o_d_w_addr        (d_addr),
        .o_d_w_dat         (d_dat),
        .o_d_w_enb         (d_enb),
        .o_i_w_addr        (i_addr),
        .o_i_w_dat         (i_dat),
        .o_i_w_enb         (i_enb),
        .o_d_bram_init_done(init_done),
        .o_pc_stall        (pc_stall),
        .o_i_r_enb         (i_r_enb),
        .o_rd_enbl         (rd_enbl),
        .o_busy            (busy),
        .o_err             (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        port;   // 0 = data BRAM, 1 = instruction BRAM
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;
    int   pc_fall = -1;
    int   init_rise = -1;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        prev_valid <= valid;
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (d_enb === 1'b1 || i_enb === 1'b1) begin
            if (d_enb === 1'b1 && i_enb === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL dual_strobe actual=both required=one (t=%0t)", $time);
            end
            chk("strobe_follows_valid", longint'(prev_valid), 1);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual=d%0b/i%0b required=none (t=%0t)",
                         d_enb, i_enb, $time);
            end else begin
                e = q.pop_front();
                chk("strobe_port", longint'(i_enb), longint'(e.port));
                chk("strobe_addr", e.port ? longint'(i_addr) : longint'(d_addr),
                    longint'(e.addr));
                chk("strobe_data", e.port ? longint'(i_dat) : longint'(d_dat),
                    longint'(e.data));
            end
        end
        if (pc_stall === 1'b0 && pc_fall < 0) pc_fall = cyc;
        if (init_done === 1'b1 && init_rise < 0) init_rise = cyc;
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_pc_stall"}, longint'(pc_stall), 1);
        chk({tag, "_init_done"}, longint'(init_done), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_src_ready"}, longint'(src_ready), 0);
        chk({tag, "_err"}, longint'(err), 0);
        chk({tag, "_i_r_enb"}, longint'(i_r_enb), 0);
        chk({tag, "_rd_enbl"}, longint'(rd_enbl), 0);
        chk({tag, "_enb"}, longint'({d_enb, i_enb}), 0);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("reset");
    endtask

    // vmode: 0 valid always high, 1 toggling 1/0, 2 random.
    // seq: words are 1,2,3,... instead of random. abort_at>0: reset after that many transfers.
    task automatic do_load(input int d, input int i, input int vmode, input bit seq,
                           input bit bad_sum, input int abort_at);
        logic [31:0] w[$];
        logic [31:0] sum;
        int          n;
        int          j;
        int          budget;
        int          d_end;
        int          last_edge;
        bit          v;
        bit          xfer;
        bit          tog;
        bit          to_error;
        exp_t        x;

        sum = 32'd0;
        for (int k = 0; k < d + i; k++) begin
            w.push_back(seq ? 32'(k + 1) : $urandom);
            sum += w[k];
            if (abort_at == 0 || k < abort_at) begin
                x.port = (k >= d);
                x.addr = 32'((k < d ? k : k - d) * 4);
                x.data = w[k];
                q.push_back(x);
            end
        end
`ifdef BOOT_CHECKSUM_EN
        w.push_back(bad_sum ? sum + 32'd1 : sum);
        to_error = bad_sum;
`else
        to_error = 1'b0;
`endif
        n         = w.size();
        j         = 0;
        budget    = 0;
        tog       = 1'b1;
        d_end     = -1;
        pc_fall   = -1;
        init_rise = -1;

        dcnt  = 8'(d);
        icnt  = 8'(i);
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        last_edge = cyc;
        if (d == 0) d_end = cyc;

        while (j < n && budget < 4000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            valid = v;
            sdata = v ? w[j] : $urandom;
            xfer  = v && (src_ready === 1'b1);
            @(posedge clk);
            #1;
            budget++;
            if (xfer) begin
                if (j == d - 1) d_end = cyc;
                last_edge = cyc;
                j++;
                if (abort_at != 0 && j == abort_at) begin
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    check_idle_outputs("abort");
                    rst   = 1'b0;
                    valid = 1'b0;
                    repeat (4) @(posedge clk);
                    #1;
                    chk("abort_queue_drained", q.size(), 0);
                    chk("abort_stays_idle", longint'({pc_stall, busy, init_done}), 3'b100);
                    return;
                end
            end
        end
        valid = 1'b0;
        if (j < n) begin
            checks++;
            failures++;
            $display("FAIL load_timeout actual=%0d required=%0d words", j, n);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        chk("init_done_cycle", init_rise, d_end);
        chk("busy_end", longint'(busy), 0);
        chk("src_ready_end", longint'(src_ready), 0);
        if (!to_error) begin
            chk("pc_fall_cycle", pc_fall, last_edge + 1);
            chk("run_pc_stall", longint'(pc_stall), 0);
            chk("run_i_r_enb", longint'(i_r_enb), 1);
            chk("run_rd_enbl", longint'(rd_enbl), 1);
            chk("run_err", longint'(err), 0);
        end else begin
            chk("error_pc_stall", longint'(pc_stall), 1);
            chk("error_err", longint'(err), 1);
            chk("error_i_r_enb", longint'(i_r_enb), 0);
            chk("error_rd_enbl", longint'(rd_enbl), 0);
            chk("error_never_released", pc_fall, -1);
        end
    endtask

    initial begin
        do_reset();

        // Straight load, valid always high
        do_load(3, 7, 0, 1'b0, 1'b0, 0);

        // Toggling valid
        do_reset();
        do_load(2, 2, 1, 1'b0, 1'b0, 0);

        // Data phase skipped
        do_reset();
        do_load(0, 1, 0, 1'b0, 1'b0, 0);

        // Reset after the 2nd of 5 data words
        do_reset();
        do_load(5, 2, 0, 1'b0, 1'b0, 2);

        // Start pulsed while in RUN must be ignored
        do_reset();
        do_load(2, 3, 2, 1'b0, 1'b0, 0);
        dcnt  = 8'd2;
        icnt  = 8'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        valid = 1'b1;
        sdata = $urandom;
        repeat (5) @(posedge clk);
        #1;
        valid = 1'b0;
        chk("run_start_pc_stall", longint'(pc_stall), 0);
        chk("run_start_busy", longint'(busy), 0);
        chk("run_start_ready", longint'(src_ready), 0);

`ifdef BOOT_CHECKSUM_EN
        do_reset();
        do_load(1, 2, 0, 1'b1, 1'b0, 0);
        do_reset();
        do_load(1, 2, 0, 1'b1, 1'b1, 0);
        do_reset();
        do_load(4, 3, 2, 1'b0, 1'b1, 0);
`endif

        // Both phases skipped
        do_reset();
        do_load(0, 0, 0, 1'b0, 1'b0, 0);

        // Randomized loads
        for (int r = 0; r < 8; r++) begin
            do_reset();
            do_load(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), 2, 1'b0,
                    1'($urandom_range(0, 1)), 0);
        end

        // Maximum counts reach byte address 0x3F8 on both ports
        do_reset();
        do_load(255, 255, 2, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boot_loader_ctrl.md
BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, 10, BRAM byte-address width.
REQ-002 Parameter: DATA_WIDTH, 32, BRAM word width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse; begins load sequence; honoured only in IDLE.
REQ-006 d_count  in  8  data words to load; sampled on accepted start; 0 skips data phase.
REQ-007 i_count  in  8  instruction words to load; sampled on accepted start; 0 skips instruction phase.
REQ-008 src_valid  in  1  source word valid.
REQ-009 src_data  in  DATA_WIDTH  source word.
REQ-010 src_ready  out  1  loader accepts word; transfer = src_valid & src_ready.
REQ-011 d_w_addr / d_w_dat / d_w_enb  out  ADDR_WIDTH / DATA_WIDTH / 1  data BRAM write port.
REQ-012 i_w_addr / i_w_dat / i_w_enb  out  ADDR_WIDTH / DATA_WIDTH / 1  instruction BRAM write port.
REQ-013 d_bram_init_done  out  1  data BRAM port handed to core.
REQ-014 pc_stall  out  1  holds PC.
REQ-015 i_r_enb / rd_enbl  out  1 / 1  instruction BRAM read enable, register-file read enable.
REQ-016 busy  out  1  load in progress; err  out  1  load failed (checksum build only).

Function
REQ-017 States SHALL be IDLE, LOAD_D, LOAD_I, CHECK (checksum build only), RUN, ERROR.
REQ-018 IDLE + start: latch counts, clear word index; next state LOAD_D if d_count!=0, else LOAD_I if i_count!=0, else CHECK/RUN.
REQ-019 src_ready SHALL be 1 exactly in LOAD_D, LOAD_I, CHECK; 0 elsewhere.
REQ-020 Each transfer in LOAD_D/LOAD_I SHALL drive exactly one write strobe of one cycle on the matching port in the next cycle, with address = word_index*4 and data = transferred word.
REQ-021 Write address/data/enable outputs SHALL be registered; enable 0 in all cycles without a preceding transfer.
REQ-022 Word index SHALL increment per transfer and clear on phase change; on the transfer of word count-1 the phase ends on the next edge (LOAD_D -> LOAD_I or its skip successor; LOAD_I -> CHECK/RUN).
REQ-023 src_valid low SHALL stall the phase indefinitely with no strobes; no timeout.
REQ-024 d_bram_init_done SHALL rise on leaving LOAD_D (or immediately after start if data phase skipped) and remain 1 until reset.
REQ-025 In RUN: pc_stall=0, i_r_enb=1, rd_enbl=1; RUN entered one cycle after the final instruction strobe so the last write lands before fetch; all else pc_stall=1, i_r_enb=0, rd_enbl=0.
REQ-026 RUN and ERROR SHALL be terminal; start ignored outside IDLE.
REQ-027 busy = 1 in LOAD_D, LOAD_I, CHECK.
REQ-028 Counts of 255 SHALL write byte addresses 0x000..0x3F8 with no wrap.

Reset
REQ-029 rst SHALL force IDLE, clear counts, index, checksum, all strobes, d_bram_init_done=0, busy=0, err=0, pc_stall=1, i_r_enb=0, rd_enbl=0, src_ready=0.
REQ-030 rst asserted mid-load SHALL abort at that edge; a strobe pending from the prior cycle SHALL NOT be issued.

Configuration
REQ-031 Macro BOOT_CHECKSUM_EN defined: running 32-bit mod-2^32 sum of all loaded words; after LOAD_I one extra word is accepted in CHECK; equal -> RUN, unequal -> ERROR with err=1, pc_stall held 1.
REQ-032 Macro BOOT_CHECKSUM_EN undefined: no CHECK state, no checksum register, err tied 0, LOAD_I end goes directly to RUN.

Verification
REQ-033 start, d_count=3, i_count=7, src_valid always 1 -> d strobes at 0x0,0x4,0x8 then i strobes 0x0..0x18, pc_stall falls 1 cycle after last i strobe.
REQ-034 src_valid toggled 1/0 each cycle, d_count=2, i_count=2 -> exactly 4 strobes, correct addresses, no strobe in valid-low cycles.
REQ-035 d_count=0, i_count=1 -> d_bram_init_done=1 the cycle after start, no d_w_enb ever, single i strobe at 0x0.
REQ-036 rst asserted after 2nd of 5 data words -> IDLE next cycle, no further strobes, pc_stall=1, d_bram_init_done=0.
REQ-037 BOOT_CHECKSUM_EN, words 0x1,0x2,0x3 then 0x6 -> RUN; same with 0x7 -> ERROR, err=1, pc_stall=1.
REQ-038 start pulsed during RUN -> no state change, no strobes.
